// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl
// Multi-cycle execute controller for a small MIPS subset. One instruction
// at a time goes through IDLE -> DECODE -> EXEC -> WB, or
// IDLE -> DECODE -> ERR when it cannot be decoded.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   instr_valid   instruction offered (sampled only in IDLE)
//   instr_ready   high only in IDLE
//   opcode/funct  MIPS opcode and funct fields (funct used for R-type)
//   alu_ctr       ALU operation select, held from DECODE exit to WB exit
//   alu_src_imm   ALU B operand is the immediate
//   alu_result    combinational ALU result for the current alu_ctr
//   z_flag        ALU zero flag
//   wb_valid      write-back data valid (whole of WB)
//   wb_ready      write-back consumer accepts
//   wb_data       ALU result captured at the end of EXEC
//   branch_taken  beq resolved taken, meaningful with wb_valid
//   illegal       one-cycle pulse when an instruction cannot be decoded
//
// Configuration macro
//   MIPS_EXEC_MUL_EN  when defined, opcode 0x00 / funct 0x18 (mult) decodes
//                     to alu_ctr=101; otherwise it is illegal.
module mips_exec_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_ctr,
    output logic        alu_src_imm,
    input  logic [31:0] alu_result,
    input  logic        z_flag,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic        branch_taken,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [5:0]  opcode_reg;
    logic [5:0]  funct_reg;
    logic [2:0]  alu_ctr_reg;
    logic        alu_src_imm_reg;
    logic        is_beq_reg;
    logic [31:0] wb_data_reg;
    logic        branch_reg;

    // Decode of the captured instruction fields
    logic        dec_legal;
    logic [2:0]  dec_ctr;
    logic        dec_imm;
    logic        dec_beq;

    always_comb begin
        dec_legal = 1'b0;
        dec_ctr   = 3'b000;
        dec_imm   = 1'b0;
        dec_beq   = 1'b0;
        case (opcode_reg)
            6'h00: begin
                case (funct_reg)
                    6'h24: begin dec_legal = 1'b1; dec_ctr = 3'b000; end // and
                    6'h25: begin dec_legal = 1'b1; dec_ctr = 3'b001; end // or
                    6'h20: begin dec_legal = 1'b1; dec_ctr = 3'b010; end // add
                    6'h22: begin dec_legal = 1'b1; dec_ctr = 3'b100; end // sub
                    6'h2A: begin dec_legal = 1'b1; dec_ctr = 3'b110; end // slt
`ifdef MIPS_EXEC_MUL_EN
                    6'h18: begin dec_legal = 1'b1; dec_ctr = 3'b101; end // mult
`else
                    6'h18: begin dec_legal = 1'b0; dec_ctr = 3'b000; end // mult not built
`endif
                    default: begin dec_legal = 1'b0; dec_ctr = 3'b000; end
                endcase
            end
            6'h23, 6'h2B, 6'h08: begin // lw, sw, addi: address/immediate add
                dec_legal = 1'b1;
                dec_ctr   = 3'b010;
                dec_imm   = 1'b1;
            end
            6'h04: begin // beq: subtract, zero flag decides
                dec_legal = 1'b1;
                dec_ctr   = 3'b100;
                dec_beq   = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = dec_legal ? S_EXEC : S_ERR;
            S_EXEC:   state_next = S_WB;
            S_WB:     if (wb_ready) state_next = S_IDLE;
            S_ERR:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_reg      <= 6'd0;
            funct_reg       <= 6'd0;
            alu_ctr_reg     <= 3'b000;
            alu_src_imm_reg <= 1'b0;
            is_beq_reg      <= 1'b0;
            wb_data_reg     <= 32'd0;
            branch_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) begin
                        opcode_reg <= opcode;
                        funct_reg  <= funct;
                    end
                end
                S_DECODE: begin
                    // An illegal decode leaves the ALU select at 000 for ERR.
                    alu_ctr_reg     <= dec_legal ? dec_ctr : 3'b000;
                    alu_src_imm_reg <= dec_legal & dec_imm;
                    is_beq_reg      <= dec_legal & dec_beq;
                end
                S_EXEC: begin
                    wb_data_reg <= alu_result;
                    branch_reg  <= is_beq_reg & z_flag;
                end
                S_WB: begin
                    if (wb_ready) begin
                        // wb_data keeps the last result; control returns to idle values.
                        alu_ctr_reg     <= 3'b000;
                        alu_src_imm_reg <= 1'b0;
                        is_beq_reg      <= 1'b0;
                        branch_reg      <= 1'b0;
                    end
                end
                default: begin
                    alu_ctr_reg     <= 3'b000;
                    alu_src_imm_reg <= 1'b0;
                    is_beq_reg      <= 1'b0;
                end
            endcase
        end
    end

    // Handshake/status outputs come straight from the state register so the
    // asynchronous reset forces them without waiting for a clock edge.
    assign instr_ready  = (state_reg == S_IDLE);
    assign wb_valid     = (state_reg == S_WB);
    assign illegal      = (state_reg == S_ERR);
    assign alu_ctr      = alu_ctr_reg;
    assign alu_src_imm  = alu_src_imm_reg;
    assign wb_data      = wb_data_reg;
    assign branch_taken = branch_reg;

endmodule

// File: tb/tb_mips_exec_ctrl.sv
module tb_mips_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic [2:0]  alu_ctr;
    logic        alu_src_imm;
    logic [31:0] alu_result;
    logic        z_flag;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_data;
    logic        branch_taken;
    logic        illegal;

    logic [31:0] a_op = 32'd0;
    logic [31:0] b_op = 32'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_exec_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .funct        (funct),
        .alu_ctr      (alu_ctr),
        .alu_src_imm  (alu_src_imm),
        .alu_result   (alu_result),
        .z_flag       (z_flag),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    // Bench-side ALU: a plain arithmetic model of the operations
    function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a - b;
            3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b101:  return a * b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_ctr, a_op, b_op);
        z_flag     = (alu_result == 32'd0);
    end

    // Instruction-set table of the model
    typedef struct packed {
        logic       legal;
        logic       beq;
        logic       imm;
        logic [2:0] ctr;
    } dec_t;

    function automatic dec_t isa_decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d = '{legal: 1'b1, beq: 1'b0, imm: 1'b0, ctr: 3'b000};
        if (op == 6'h00) begin
            if      (fn == 6'h24) d.ctr = 3'b000;
            else if (fn == 6'h25) d.ctr = 3'b001;
            else if (fn == 6'h20) d.ctr = 3'b010;
            else if (fn == 6'h22) d.ctr = 3'b100;
            else if (fn == 6'h2A) d.ctr = 3'b110;
`ifdef MIPS_EXEC_MUL_EN
            else if (fn == 6'h18) d.ctr = 3'b101;
`endif
            else d.legal = 1'b0;
        end else if (op == 6'h23 || op == 6'h2B || op == 6'h08) begin
            d.ctr = 3'b010;
            d.imm = 1'b1;
        end else if (op == 6'h04) begin
            d.ctr = 3'b100;
            d.beq = 1'b1;
        end else begin
            d.legal = 1'b0;
        end
        if (!d.legal) d.ctr = 3'b000;
        return d;
    endfunction

    // Transaction model: busy flag plus the number of clock edges since accept
    logic        m_busy = 1'b0;
    int          m_age  = 0;
    dec_t        m_dec  = '0;
    logic [31:0] m_data = 32'd0;
    logic        m_br   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_dec  <= '0;
            m_data <= 32'd0;
            m_br   <= 1'b0;
        end else if (!m_busy) begin
            if (instr_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_dec  <= isa_decode(opcode, funct);
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (m_age == 2) begin
            if (m_dec.legal) begin
                m_age  <= 3;
                m_data <= alu_fn(m_dec.ctr, a_op, b_op);
                m_br   <= m_dec.beq && (alu_fn(m_dec.ctr, a_op, b_op) == 32'd0);
            end else begin
                m_busy <= 1'b0;
            end
        end else if (wb_ready) begin
            m_busy <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic e_wbv, e_ill;
        logic [2:0] e_ctr;
        logic e_imm;
        e_wbv = m_busy && (m_age == 3);
        e_ill = m_busy && (m_age == 2) && !m_dec.legal;
        e_ctr = (m_busy && m_dec.legal && m_age >= 2) ? m_dec.ctr : 3'b000;
        e_imm = m_busy && m_dec.legal && (m_age >= 2) && m_dec.imm;
        chk("cyc instr_ready", {31'd0, instr_ready}, {31'd0, !m_busy});
        chk("cyc wb_valid",    {31'd0, wb_valid},    {31'd0, e_wbv});
        chk("cyc illegal",     {31'd0, illegal},     {31'd0, e_ill});
        chk("cyc alu_ctr",     {29'd0, alu_ctr},     {29'd0, e_ctr});
        chk("cyc alu_src_imm", {31'd0, alu_src_imm}, {31'd0, e_imm});
        chk("cyc wb_data",     wb_data,              m_data);
        chk("cyc branch",      {31'd0, branch_taken}, {31'd0, e_wbv && m_br});
    end

    // Directed transaction with hand-computed expectations.
    // hold = number of WB cycles with wb_ready low before acceptance.
    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input int hold,
                       input bit keep_valid, input bit exp_ill, input logic [2:0] exp_ctr,
                       input logic exp_imm, input logic [31:0] exp_data, input logic exp_br);
        int first_wb = 0;
        int wbcnt = 0;
        int ill_cnt = 0;
        logic [2:0] ctr_exec = 3'b000;
        logic imm_exec = 1'b0;
        logic [31:0] d0 = 32'd0;
        logic br = 1'b0;
        bit done = 1'b0;
        @(posedge clk); #1;
        a_op = a; b_op = b; opcode = op; funct = fn;
        instr_valid = 1'b1;
        wb_ready = (hold == 0);
        @(posedge clk); #1;
        if (keep_valid) opcode = 6'h3F;  // garbage offered while busy must be ignored
        else instr_valid = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (c == 2) begin
                ctr_exec = alu_ctr;
                imm_exec = alu_src_imm;
            end
            if (illegal) ill_cnt++;
            if (wb_valid) begin
                wbcnt++;
                if (wbcnt == 1) begin
                    first_wb = c;
                    d0 = wb_data;
                end else begin
                    chk({nm, " data hold"}, wb_data, d0);
                end
                if (wbcnt == hold + 1) wb_ready = 1'b1;
                if (wb_ready) begin
                    br = branch_taken;
                    instr_valid = 1'b0;
                    done = 1'b1;
                end
            end
            if (exp_ill && c == 3) begin
                chk({nm, " ready after err"}, {31'd0, instr_ready}, 32'd1);
                done = 1'b1;
            end
        end
        instr_valid = 1'b0;
        wb_ready = 1'b1;
        chk({nm, " completed"}, {31'd0, done}, 32'd1);
        chk({nm, " exec alu_ctr"}, {29'd0, ctr_exec}, {29'd0, exp_ctr});
        chk({nm, " exec alu_src_imm"}, {31'd0, imm_exec}, {31'd0, exp_imm});
        chk({nm, " illegal pulses"}, ill_cnt, exp_ill ? 32'd1 : 32'd0);
        if (!exp_ill) begin
            chk({nm, " wb latency"}, first_wb, 32'd3);
            chk({nm, " wb cycles"}, wbcnt, hold + 1);
            chk({nm, " wb_data"}, d0, exp_data);
            chk({nm, " branch_taken"}, {31'd0, br}, {31'd0, exp_br});
        end else begin
            chk({nm, " wb cycles"}, wbcnt, 32'd0);
        end
        $display("[TB] %s: alu_ctr=%0b imm=%0b illegal_pulses=%0d wb_cycles=%0d wb_data=0x%0h branch=%0b",
                 nm, ctr_exec, imm_exec, ill_cnt, wbcnt, d0, br);
    endtask

    initial begin
        int wbc;
        int first;
        logic [31:0] dres;
        repeat (3) @(negedge clk);
        chk("reset instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset wb_data", wb_data, 32'd0);
        rst_n = 1'b1;

        //   name     op     fn     a             b          hold kv ill ctr    imm  data           br
        run("add",   6'h00, 6'h20, 32'd3,        32'd4,        0, 0, 0, 3'b010, 0, 32'h0000_0007, 0);
        run("beq_z", 6'h04, 6'h00, 32'd9,        32'd9,        0, 0, 0, 3'b100, 0, 32'h0000_0000, 1);
        run("beq_n", 6'h04, 6'h00, 32'd9,        32'd5,        0, 0, 0, 3'b100, 0, 32'h0000_0004, 0);
        run("addi",  6'h08, 6'h00, 32'h10,       32'h20,       5, 1, 0, 3'b010, 1, 32'h0000_0030, 0);
        run("op3f",  6'h3F, 6'h00, 32'd1,        32'd1,        0, 0, 1, 3'b000, 0, 32'h0,         0);
`ifdef MIPS_EXEC_MUL_EN
        run("mult",  6'h00, 6'h18, 32'd6,        32'd7,        0, 0, 0, 3'b101, 0, 32'd42,        0);
`else
        run("mult",  6'h00, 6'h18, 32'd6,        32'd7,        0, 0, 1, 3'b000, 0, 32'h0,         0);
`endif
        run("sub",   6'h00, 6'h22, 32'd10,       32'd3,        0, 0, 0, 3'b100, 0, 32'h0000_0007, 0);
        run("slt",   6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1,       0, 0, 0, 3'b110, 0, 32'h0000_0001, 0);
        run("and",   6'h00, 6'h24, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 3'b000, 0, 32'h0000_F000, 0);
        run("or",    6'h00, 6'h25, 32'h0000_F0F0, 32'h0000_FF00, 1, 0, 0, 3'b001, 0, 32'h0000_FFF0, 0);
        run("lw",    6'h23, 6'h00, 32'h100,      32'd4,        0, 0, 0, 3'b010, 1, 32'h0000_0104, 0);
        run("sw",    6'h2B, 6'h00, 32'h200,      32'd8,        2, 0, 0, 3'b010, 1, 32'h0000_0208, 0);
        run("fn21",  6'h00, 6'h21, 32'd1,        32'd2,        0, 0, 1, 3'b000, 0, 32'h0,         0);

        // Reset asserted while in EXEC
        @(posedge clk); #1;
        a_op = 32'd3; b_op = 32'd4; opcode = 6'h00; funct = 6'h20;
        instr_valid = 1'b1; wb_ready = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst pre alu_ctr", {29'd0, alu_ctr}, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst alu_ctr", {29'd0, alu_ctr}, 32'd0);
        chk("rst alu_src_imm", {31'd0, alu_src_imm}, 32'd0);
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst branch", {31'd0, branch_taken}, 32'd0);
        chk("rst illegal", {31'd0, illegal}, 32'd0);
        // Offer an instruction during reset; it must be taken on the first edge after release.
        a_op = 32'd20; b_op = 32'd22;
        instr_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wbc = 0; first = 0; dres = 32'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("post-rst accept", {31'd0, instr_ready}, 32'd0);
            if (wb_valid) begin
                wbc++;
                if (wbc == 1) begin first = c; dres = wb_data; end
            end
        end
        chk("post-rst wb count", wbc, 32'd1);
        chk("post-rst latency", first, 32'd3);
        chk("post-rst wb_data", dres, 32'd42);
        $display("[TB] reset-in-exec: wb_cycles_after_release=%0d first=%0d wb_data=0x%0h", wbc, first, dres);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_exec_ctrl.md
MIPS_EXEC_CTRL -- requirements
Module: mips_exec_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: instr_valid  input  1  instruction offered.
REQ-004 SHALL have ports: instr_ready  output  1  controller can accept an instruction.
REQ-005 SHALL have ports: opcode  input  6  MIPS opcode field.
REQ-006 SHALL have ports: funct  input  6  MIPS funct field, R-type only.
REQ-007 SHALL have ports: alu_ctr  output  3  operation select to the ALU.
REQ-008 SHALL have ports: alu_src_imm  output  1  ALU B operand is the immediate.
REQ-009 SHALL have ports: alu_result  input  32  ALU result, combinational from alu_ctr.
REQ-010 SHALL have ports: z_flag  input  1  ALU zero flag.
REQ-011 SHALL have ports: wb_valid  output  1  write-back data valid.
REQ-012 SHALL have ports: wb_ready  input  1  write-back consumer accepts.
REQ-013 SHALL have ports: wb_data  output  32  captured ALU result.
REQ-014 SHALL have ports: branch_taken  output  1  beq resolved taken, valid with wb_valid.
REQ-015 SHALL have ports: illegal  output  1  one-cycle pulse on an undecodable instruction.

Function
REQ-016 SHALL implement the FSM states IDLE, DECODE, EXEC, WB and ERR.
REQ-017 SHALL drive instr_ready=1 only in IDLE.
REQ-018 SHALL register opcode/funct and go IDLE->DECODE when IDLE and instr_valid=1.
REQ-019 SHALL decode in DECODE and register alu_ctr/alu_src_imm, going to EXEC if legal and ERR if not.
REQ-020 SHALL decode opcode 0x00 by funct: 0x24->000, 0x25->001, 0x20->010, 0x22->100, 0x2A->110; alu_src_imm=0.
REQ-021 SHALL decode lw 0x23, sw 0x2B and addi 0x08 as 010 with alu_src_imm=1.
REQ-022 SHALL decode beq 0x04 as 100 with alu_src_imm=0.
REQ-023 SHALL treat every other opcode/funct combination as illegal.
REQ-024 SHALL hold alu_ctr stable from DECODE exit until WB exit, and drive 3'b000 in IDLE, ERR and reset.
REQ-025 SHALL capture alu_result into wb_data and record z_flag on the EXEC->WB edge (EXEC lasts exactly one cycle).
REQ-026 SHALL assert wb_valid throughout WB and hold wb_data/branch_taken constant until wb_ready=1.
REQ-027 SHALL set branch_taken=1 only for beq with captured z_flag=1; otherwise 0.
REQ-028 SHALL return WB->IDLE on the cycle wb_valid=1 and wb_ready=1, with no same-cycle re-accept.
REQ-029 SHALL give a latency of exactly 3 cycles from the accept edge to the first wb_valid=1 cycle when wb_ready=1 is held.
REQ-030 SHALL pulse illegal=1 for exactly one cycle in ERR, without wb_valid, then return to IDLE.
REQ-031 SHALL ignore instr_valid outside IDLE, with no capture and no effect.

Reset
REQ-032 SHALL on rst_n=0 immediately force IDLE, instr_ready=1, alu_ctr=000, alu_src_imm=0, wb_valid=0, wb_data=0, branch_taken=0 and illegal=0.
REQ-033 SHALL on reset mid-operation (any state) discard the instruction without emitting wb_valid or illegal.
REQ-034 SHALL leave reset synchronously to clk, and SHALL accept an instruction on the first rising edge with rst_n=1.

Configuration
REQ-035 SHALL with MIPS_EXEC_MUL_EN defined decode opcode 0x00/funct 0x18 as alu_ctr=101, alu_src_imm=0, executed as a normal R-type.
REQ-036 SHALL without MIPS_EXEC_MUL_EN treat opcode 0x00/funct 0x18 as illegal (ERR, illegal pulse), with all other decodes unchanged.

Verification
REQ-037 SHALL cover: add (op 00, funct 20) with bench ALU result 0x0000_0007, wb_ready=1 -> alu_ctr=010 in EXEC; wb_valid on 3rd cycle after accept, wb_data=0x7, branch_taken=0.
REQ-038 SHALL cover: beq (op 04) with z_flag=1 -> alu_ctr=100, branch_taken=1; repeat with z_flag=0 -> branch_taken=0.
REQ-039 SHALL cover: addi (op 08) with wb_ready=0 for 5 cycles -> alu_src_imm=1, wb_valid held 6 cycles with constant wb_data, instr_ready=0 throughout.
REQ-040 SHALL cover: op 0x3F -> illegal high exactly 1 cycle, wb_valid never set, instr_ready=1 on the following cycle.
REQ-041 SHALL cover: mult (funct 18) -> alu_ctr=101 with MIPS_EXEC_MUL_EN defined, illegal pulse without it.
REQ-042 SHALL cover: rst_n=0 asserted in EXEC -> outputs at reset values before the next clk edge; no wb_valid after release.
